id_decode_stage: RTL and testbench

- IF/ID pipeline register plus main instruction decoder for the 5-stage MIPS core.
- Captures the fetched instruction and PC and presents registered decode fields one cycle later.
- imm16 and sign_extend drive the sign-extension unit.
- Also provides register specifiers and control signals to the ID/EX stage and the hazard unit.

---
 rtl/mips_defs_pkg.sv | 78 +++++++
 rtl/id_decode_stage_main_dec.sv | 94 +++++++++
 rtl/id_decode_stage.sv | 131 +++++++++++++
 tb/tb_id_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: shared MIPS decode definitions.
//   - opcode (OP_*) and R-type funct (FN_*) encodings
//   - alu_op_e: ALU operation code driven to the execute stage
//   - ctrl_t: bundle of main-decoder control outputs
//   - NOP_INST: instruction word used to squash a pipeline slot (sll $0,$0,0)
//   - is_zero_ext_op(): opcodes whose 16-bit immediate is zero-extended
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    link;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  // Logical immediates (ANDI/ORI/XORI) and LUI take imm16 unsigned.
  function automatic logic is_zero_ext_op(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
           (opcode == OP_XORI) || (opcode == OP_LUI);
  endfunction

endpackage

// File: rtl/id_decode_stage_main_dec.sv
// main_dec: purely combinational MIPS main decoder.
// Ports:
//   opcode      in  6   inst[31:26]
//   funct       in  6   inst[5:0]
//   ctrl        out     control bundle (controls, alu_op, illegal), ungated
//   sign_extend out 1   1 = sign-extend imm16, 0 = zero-extend
// Unsupported opcode/funct yields illegal=1 with every control low.
module main_dec
  import mips_defs_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       sign_extend
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    sign_extend = ~is_zero_ext_op(opcode);

    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_SRA:          ctrl.alu_op = ALU_SRA;
          FN_JR: begin
            // Register jump: no writeback, target comes from rs.
            ctrl.reg_write = 1'b0;
            ctrl.reg_dst   = 1'b0;
            ctrl.jump      = 1'b1;
          end
          default: begin
            ctrl         = '0;
            ctrl.alu_op  = ALU_ADD;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        // $31 is selected downstream from link.
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch_eq = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        case (opcode)
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          OP_SLTIU: ctrl.alu_op = ALU_SLTU;
          OP_ANDI:  ctrl.alu_op = ALU_AND;
          OP_ORI:   ctrl.alu_op = ALU_OR;
          OP_XORI:  ctrl.alu_op = ALU_XOR;
          OP_LUI:   ctrl.alu_op = ALU_LUI;
          default:  ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: IF/ID pipeline register plus main decoder.
// Captures the fetched instruction/PC; decode outputs are combinational
// from the registered instruction, so they appear one cycle after capture.
// Ports:
//   clk, rst                 clock, async active-high reset
//   if_valid/if_inst/if_pc   fetch slot
//   stall                    hold IF/ID contents
//   flush                    squash IF/ID contents (wins over stall)
//   id_valid/id_pc/id_pc_plus4
//   rs rt rd shamt imm16 jidx  raw fields, always reflect the held word
//   sign_extend              immediate extension mode for imm16
//   reg_write..link, alu_op  main-decoder controls
//   illegal                  valid slot holds unsupported opcode/funct
// Optional build macro ID_PERF_CNT_EN adds perf_inst_cnt/perf_stall_cnt.
// Handshake: no backpressure here; stall/flush are sampled every edge
// and a slot is live only while id_valid=1.
module id_decode_stage
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = mips_defs_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic        sign_extend,
  output logic [25:0] jidx,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump,
  output logic        link,
  output alu_op_e     alu_op,
  output logic        illegal
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic [31:0] id_inst;
  ctrl_t       dec_ctrl;
  ctrl_t       out_ctrl;

  // IF/ID register: flush > stall > load. Flush keeps id_pc so the
  // squashed slot still carries a meaningful PC for debug.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst  <= NOP_INST;
      id_pc    <= RESET_PC;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_inst  <= if_inst;
      id_pc    <= if_pc;
      id_valid <= if_valid;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (id_valid && !stall && !flush) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (stall && !flush)              perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign id_pc_plus4 = id_pc + 32'd4;
  assign rs          = id_inst[25:21];
  assign rt          = id_inst[20:16];
  assign rd          = id_inst[15:11];
  assign shamt       = id_inst[10:6];
  assign imm16       = id_inst[15:0];
  assign jidx        = id_inst[25:0];

  main_dec u_main_dec (
    .opcode      (id_inst[31:26]),
    .funct       (id_inst[5:0]),
    .ctrl        (dec_ctrl),
    .sign_extend (sign_extend)
  );

  // An empty slot (reset, flush, bubble) decodes the NOP word as sll, so
  // every control is cleared here rather than only the side-effecting
  // ones; this gives a clean all-zero/ALU_ADD bundle for empty slots.
  always_comb begin
    out_ctrl = dec_ctrl;
    if (!id_valid) begin
      out_ctrl        = '0;
      out_ctrl.alu_op = ALU_ADD;
    end
  end

  assign reg_write  = out_ctrl.reg_write;
  assign reg_dst    = out_ctrl.reg_dst;
  assign alu_src    = out_ctrl.alu_src;
  assign mem_read   = out_ctrl.mem_read;
  assign mem_write  = out_ctrl.mem_write;
  assign mem_to_reg = out_ctrl.mem_to_reg;
  assign branch_eq  = out_ctrl.branch_eq;
  assign branch_ne  = out_ctrl.branch_ne;
  assign jump       = out_ctrl.jump;
  assign link       = out_ctrl.link;
  assign alu_op     = out_ctrl.alu_op;
  assign illegal    = out_ctrl.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: scoreboard bench for id_decode_stage.
// Honors ID_PERF_CNT_EN when the design is built with it.
module tb_id_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [61:0] fields;   // {rs, rt, rd, shamt, imm16, jidx}
    logic        se;
    logic [9:0]  ctl;      // {rw, rdst, asrc, mr, mw, m2r, beq, bne, j, lnk}
    logic [3:0]  alu;
    logic        ill;
    logic [31:0] pic;
    logic [31:0] psc;
  } obs_t;

  localparam int W = $bits(obs_t);
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  logic id_valid;
  logic [31:0] id_pc, id_pc_plus4;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic sign_extend;
  logic [25:0] jidx;
  logic reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg;
  logic branch_eq, branch_ne, jump, link, illegal;
  mips_defs_pkg::alu_op_e alu_op;
`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: contents of the IF/ID slot.
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_pc = RST_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_pic = '0;
  logic [31:0] m_psc = '0;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm16(imm16), .sign_extend(sign_extend), .jidx(jidx),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .link(link),
    .alu_op(alu_op), .illegal(illegal)
`ifdef ID_PERF_CNT_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outputs from the instruction set: name the instruction, then
  // read its properties off a mnemonic table.
  function automatic obs_t model_obs(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic v, input logic [31:0] pic,
                                     input logic [31:0] psc);
    obs_t o;
    string mn;
    logic [5:0] op, fn;
    logic rw, rdst, asrc, mr, mw, m2r, beq, bne, j, lnk, ill;
    logic [3:0] alu;
    op = inst[31:26];
    fn = inst[5:0];
    mn = "bad";
    case (op)
      6'h00: case (fn)
        6'h20: mn = "add";  6'h21: mn = "addu"; 6'h22: mn = "sub";
        6'h23: mn = "subu"; 6'h24: mn = "and";  6'h25: mn = "or";
        6'h26: mn = "xor";  6'h27: mn = "nor";  6'h2A: mn = "slt";
        6'h2B: mn = "sltu"; 6'h00: mn = "sll";  6'h02: mn = "srl";
        6'h03: mn = "sra";  6'h08: mn = "jr";
        default: mn = "bad";
      endcase
      6'h02: mn = "j";     6'h03: mn = "jal";   6'h04: mn = "beq";
      6'h05: mn = "bne";   6'h08: mn = "addi";  6'h09: mn = "addiu";
      6'h0A: mn = "slti";  6'h0B: mn = "sltiu"; 6'h0C: mn = "andi";
      6'h0D: mn = "ori";   6'h0E: mn = "xori";  6'h0F: mn = "lui";
      6'h23: mn = "lw";    6'h2B: mn = "sw";
      default: mn = "bad";
    endcase
    {rw, rdst, asrc, mr, mw, m2r, beq, bne, j, lnk, ill} = '0;
    alu = 4'd0;
    case (mn)
      "add", "addu": begin rw = 1; rdst = 1; alu = 4'd0; end
      "sub", "subu": begin rw = 1; rdst = 1; alu = 4'd1; end
      "and":  begin rw = 1; rdst = 1; alu = 4'd2; end
      "or":   begin rw = 1; rdst = 1; alu = 4'd3; end
      "xor":  begin rw = 1; rdst = 1; alu = 4'd4; end
      "nor":  begin rw = 1; rdst = 1; alu = 4'd5; end
      "slt":  begin rw = 1; rdst = 1; alu = 4'd6; end
      "sltu": begin rw = 1; rdst = 1; alu = 4'd7; end
      "sll":  begin rw = 1; rdst = 1; alu = 4'd8; end
      "srl":  begin rw = 1; rdst = 1; alu = 4'd9; end
      "sra":  begin rw = 1; rdst = 1; alu = 4'd10; end
      "jr":   j = 1;
      "j":    j = 1;
      "jal":  begin j = 1; lnk = 1; rw = 1; end
      "beq":  begin beq = 1; alu = 4'd1; end
      "bne":  begin bne = 1; alu = 4'd1; end
      "addi", "addiu": begin rw = 1; asrc = 1; alu = 4'd0; end
      "slti":  begin rw = 1; asrc = 1; alu = 4'd6; end
      "sltiu": begin rw = 1; asrc = 1; alu = 4'd7; end
      "andi":  begin rw = 1; asrc = 1; alu = 4'd2; end
      "ori":   begin rw = 1; asrc = 1; alu = 4'd3; end
      "xori":  begin rw = 1; asrc = 1; alu = 4'd4; end
      "lui":   begin rw = 1; asrc = 1; alu = 4'd11; end
      "lw":    begin rw = 1; asrc = 1; mr = 1; m2r = 1; end
      "sw":    begin asrc = 1; mw = 1; end
      default: ill = 1;
    endcase
    o = '0;
    o.valid  = v;
    o.pc     = pc;
    o.pc4    = pc + 32'd4;
    o.fields = {inst[25:21], inst[20:16], inst[15:11], inst[10:6], inst[15:0], inst[25:0]};
    o.se     = !(op >= 6'h0C && op <= 6'h0F);
    if (v) begin
      o.ctl = {rw, rdst, asrc, mr, mw, m2r, beq, bne, j, lnk};
      o.alu = alu;
      o.ill = ill;
    end
    o.pic = pic;
    o.psc = psc;
    return o;
  endfunction

  // Driver: apply one cycle of inputs, advance the model at the edge,
  // then queue the response expected after that edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic st, input logic fl);
    if_valid = v; if_inst = inst; if_pc = pc; stall = st; flush = fl;
    @(posedge clk);
    #1;
    if (rst) begin
      m_inst = 32'h0; m_pc = RST_PC; m_valid = 1'b0; m_pic = '0; m_psc = '0;
    end else begin
      if (m_valid && !st && !fl) m_pic = m_pic + 32'd1;
      if (st && !fl) m_psc = m_psc + 32'd1;
      if (fl) begin
        m_inst = 32'h0; m_valid = 1'b0;
      end else if (!st) begin
        m_inst = inst; m_pc = pc; m_valid = v;
      end
    end
    exp_q.push_back(model_obs(m_inst, m_pc, m_valid, m_pic, m_psc));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fns[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 13)]; end
      2: r[31:26] = ops[$urandom_range(0, 14)];
      default: r[31:26] = 6'h00;
    endcase
    return r;
  endfunction

  task automatic check_reset_direct(input string tag);
    chk({tag, "_valid"}, 64'(id_valid), 64'd0);
    chk({tag, "_pc"}, 64'(id_pc), 64'(RST_PC));
    chk({tag, "_pc4"}, 64'(id_pc_plus4), 64'(RST_PC + 32'd4));
    chk({tag, "_ctl"}, 64'({reg_write, reg_dst, alu_src, mem_read, mem_write,
                            mem_to_reg, branch_eq, branch_ne, jump, link, illegal}), 64'd0);
    chk({tag, "_alu"}, 64'(alu_op), 64'd0);
    chk({tag, "_fields"}, 64'({rs, rt, rd, shamt, imm16}), 64'd0);
`ifdef ID_PERF_CNT_EN
    chk({tag, "_perf"}, {perf_inst_cnt, perf_stall_cnt}, 64'd0);
`endif
  endtask

  // Monitor: every falling edge, pop one expectation and compare.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = obs_t'(exp_q.pop_front());
        a = '0;
        a.valid  = id_valid;
        a.pc     = id_pc;
        a.pc4    = id_pc_plus4;
        a.fields = {rs, rt, rd, shamt, imm16, jidx};
        a.se     = sign_extend;
        a.ctl    = {reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg,
                    branch_eq, branch_ne, jump, link};
        a.alu    = alu_op;
        a.ill    = illegal;
        chk("id_valid", 64'(a.valid), 64'(e.valid));
        chk("id_pc", 64'(a.pc), 64'(e.pc));
        chk("id_pc_plus4", 64'(a.pc4), 64'(e.pc4));
        chk("fields", 64'(a.fields), 64'(e.fields));
        chk("sign_extend", 64'(a.se), 64'(e.se));
        chk("controls", 64'(a.ctl), 64'(e.ctl));
        chk("alu_op", 64'(a.alu), 64'(e.alu));
        chk("illegal", 64'(a.ill), 64'(e.ill));
`ifdef ID_PERF_CNT_EN
        chk("perf_inst_cnt", 64'(perf_inst_cnt), 64'(e.pic));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(e.psc));
`endif
      end
    end
  end

  // Stimulus
  initial begin
    #12;
    check_reset_direct("reset");
    @(negedge clk);
    rst = 1'b0;

    step(1, 32'h2008FFFF, 32'h0040_0000, 0, 0);   // ADDI $8,$0,-1
    step(1, 32'h3508FFFF, 32'h0040_0004, 0, 0);   // ORI
    step(1, 32'h3C011234, 32'h0040_0008, 0, 0);   // LUI
    step(1, 32'h31088000, 32'h0040_000C, 0, 0);   // ANDI imm16[15]=1
    step(1, 32'hAFA80004, 32'h0040_0010, 0, 0);   // SW
    for (int i = 0; i < 3; i++) step(1, rand_inst(), $urandom, 1, 0);
    step(1, rand_inst(), $urandom, 1, 1);          // stall+flush: flush wins
    step(1, 32'hFC000000, 32'h0040_0020, 0, 0);   // opcode 0x3F
    step(0, 32'hFC000000, 32'h0040_0024, 0, 0);   // same, empty slot
    step(1, 32'h0C100000, 32'h0040_0028, 0, 0);   // JAL
    step(1, 32'h03E00008, 32'h0040_002C, 0, 0);   // JR $31
    step(1, 32'h8FA80000, 32'hFFFF_FFFC, 0, 0);   // LW, pc+4 wraps

    // Async reset mid-stall: outputs must clear without a clock edge.
    step(1, rand_inst(), $urandom, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_direct("async_rst");
    step(1, rand_inst(), $urandom, 1, 0);
    rst = 1'b0;

    // Five retired instructions and two stall cycles after reset.
    for (int i = 0; i < 6; i++) step(1, rand_inst(), 32'h0040_0100 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 2; i++) step(1, rand_inst(), $urandom, 1, 0);
`ifdef ID_PERF_CNT_EN
    chk("perf_inst_5", 64'(perf_inst_cnt), 64'd5);
    chk("perf_stall_2", 64'(perf_stall_cnt), 64'd2);
`endif

    for (int i = 0; i < 500; i++) begin
      step(logic'($urandom_range(0, 3) != 0), rand_inst(), $urandom,
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
